// File: rtl/ro_puf_axil_pkg.sv
// Shared constants, register-array type and write-strobe merge helper for the
// RO-PUF AXI4-Lite register slave.
package ro_puf_axil_pkg;

   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STRB_W   = DATA_W / 8;

   // Byte offsets of the four word registers
   localparam logic [3:0] REG0_OFFSET = 4'h0;
   localparam logic [3:0] REG1_OFFSET = 4'h4;
   localparam logic [3:0] REG2_OFFSET = 4'h8;
   localparam logic [3:0] REG3_OFFSET = 4'hC;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

   // Replace only the bytes whose strobe bit is set
   function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ro_puf_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the RO-PUF core.
// AW and W are captured independently into holding registers; the write commits
// one cycle after both are held. Reads register the addressed value on AR handshake.
module ro_puf_axil_slave
   import ro_puf_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_o,
   output logic [NUM_REGS-1:0]                    wr_pulse_o
);

   logic              aw_held_q, aw_held_d;
   logic [1:0]        aw_idx_q, aw_idx_d;
   logic              w_held_q, w_held_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   reg_array_t        regs_q, regs_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic aw_hs, w_hs, ar_hs, commit;

   // Word index comes from address bits [3:2]; byte lane bits and PROT are don't-care
   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Readies are forced low while reset is asserted, not just after the first reset edge
   assign S_AXI_AWREADY = ~ARESET & ~aw_held_q & ~bvalid_q;
   assign S_AXI_WREADY  = ~ARESET & ~w_held_q & ~bvalid_q;
   assign S_AXI_ARREADY = ~ARESET & ~rvalid_q;

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit = aw_held_q & w_held_q;

   assign S_AXI_BRESP  = RESP_OKAY;
   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_RRESP  = RESP_OKAY;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign reg_o        = regs_q;
   assign wr_pulse_o   = wr_pulse_q;

   // Write path: capture AW/W, commit once both are held, hold B until accepted
   always_comb begin
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      if (commit) begin
         regs_d[aw_idx_q]     = strb_merge(regs_q[aw_idx_q], w_data_q, w_strb_q);
         aw_held_d            = 1'b0;
         w_held_d             = 1'b0;
         bvalid_d             = 1'b1;
         wr_pulse_d[aw_idx_q] = 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   // Read path: sample pre-write register contents on AR handshake, hold until RREADY
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         wr_pulse_q <= '0;
         regs_q     <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ro_puf_axil_slave.sv
// Randomized scoreboard bench for ro_puf_axil_slave. Stimulus tasks push the
// expected B/R responses and write pulses; a negedge monitor pops and compares.
module tb_ro_puf_axil_slave;

   localparam int TMO = 200;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [3:0]        S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [3:0]        S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;
   logic [3:0][31:0]  reg_o;
   logic [3:0]        wr_pulse_o;

   always #5 ACLK = ~ACLK;

   ro_puf_axil_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .S_AXI_AWADDR (S_AXI_AWADDR),
      .S_AXI_AWPROT (S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA  (S_AXI_WDATA),
      .S_AXI_WSTRB  (S_AXI_WSTRB),
      .S_AXI_WVALID (S_AXI_WVALID),
      .S_AXI_WREADY (S_AXI_WREADY),
      .S_AXI_BRESP  (S_AXI_BRESP),
      .S_AXI_BVALID (S_AXI_BVALID),
      .S_AXI_BREADY (S_AXI_BREADY),
      .S_AXI_ARADDR (S_AXI_ARADDR),
      .S_AXI_ARPROT (S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA  (S_AXI_RDATA),
      .S_AXI_RRESP  (S_AXI_RRESP),
      .S_AXI_RVALID (S_AXI_RVALID),
      .S_AXI_RREADY (S_AXI_RREADY),
      .reg_o        (reg_o),
      .wr_pulse_o   (wr_pulse_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: plain array of register words
   logic [31:0] model [4];
   logic [1:0]  exp_b [$];
   logic [31:0] exp_r [$];
   logic [3:0]  exp_p [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
      return (old & ~m) | (d & m);
   endfunction

   // Monitor: compare every completed response/pulse against the scoreboard
   logic [3:0] prev_pulse = '0;
   always @(negedge ACLK) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
         if (exp_b.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
         else chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_b.pop_front()});
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
         if (exp_r.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
         else begin
            chk("rdata", S_AXI_RDATA, exp_r.pop_front());
            chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
         end
      end
      if (wr_pulse_o != 4'd0) begin
         if (exp_p.size() == 0) chk("pulse_unexpected", {28'd0, wr_pulse_o}, 32'd0);
         else chk("wr_pulse", {28'd0, wr_pulse_o}, {28'd0, exp_p.pop_front()});
         chk("pulse_width", {28'd0, prev_pulse}, 32'd0);
      end
      prev_pulse <= wr_pulse_o;
   end

   // All channel tasks start and end #1 after a rising edge
   task automatic aw_chan(input logic [3:0] a, input int dly);
      int n = 0;
      if (dly > 0) begin
         repeat (dly) @(posedge ACLK);
         #1;
      end
      S_AXI_AWADDR  = a;
      S_AXI_AWPROT  = 3'($urandom);
      S_AXI_AWVALID = 1'b1;
      do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < TMO);
      if (!S_AXI_AWREADY) chk("aw_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_AWADDR  = 4'($urandom);
   endtask

   task automatic w_chan(input logic [31:0] d, input logic [3:0] s, input int dly);
      int n = 0;
      if (dly > 0) begin
         repeat (dly) @(posedge ACLK);
         #1;
      end
      S_AXI_WDATA  = d;
      S_AXI_WSTRB  = s;
      S_AXI_WVALID = 1'b1;
      do begin @(negedge ACLK); n++; end while (!S_AXI_WREADY && n < TMO);
      if (!S_AXI_WREADY) chk("w_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
      S_AXI_WDATA  = $urandom;
   endtask

   task automatic b_chan(input int bdly);
      int n = 0;
      S_AXI_BREADY = (bdly == 0);
      do begin @(negedge ACLK); n++; end while (!S_AXI_BVALID && n < TMO);
      if (!S_AXI_BVALID) begin
         chk("b_timeout", 32'd0, 32'd1);
         S_AXI_BREADY = 1'b0;
         return;
      end
      if (bdly > 0) begin
         for (int i = 0; i < bdly; i++) begin
            @(negedge ACLK);
            chk("bvalid_hold", {31'd0, S_AXI_BVALID}, 32'd1);
            chk("awready_blocked", {31'd0, S_AXI_AWREADY}, 32'd0);
            chk("wready_blocked", {31'd0, S_AXI_WREADY}, 32'd0);
         end
         @(posedge ACLK); #1;
         S_AXI_BREADY = 1'b1;
         @(negedge ACLK);
      end
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic ar_chan(input logic [3:0] a, input int dly);
      int n = 0;
      if (dly > 0) begin
         repeat (dly) @(posedge ACLK);
         #1;
      end
      S_AXI_ARADDR  = a;
      S_AXI_ARPROT  = 3'($urandom);
      S_AXI_ARVALID = 1'b1;
      do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < TMO);
      if (!S_AXI_ARREADY) chk("ar_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      S_AXI_ARADDR  = 4'($urandom);
   endtask

   task automatic r_chan(input logic [31:0] e, input int rdly);
      int n = 0;
      S_AXI_RREADY = (rdly == 0);
      do begin @(negedge ACLK); n++; end while (!S_AXI_RVALID && n < TMO);
      if (!S_AXI_RVALID) begin
         chk("r_timeout", 32'd0, 32'd1);
         S_AXI_RREADY = 1'b0;
         return;
      end
      if (rdly > 0) begin
         for (int i = 0; i < rdly; i++) begin
            S_AXI_ARADDR = 4'($urandom);
            @(negedge ACLK);
            chk("rvalid_hold", {31'd0, S_AXI_RVALID}, 32'd1);
            chk("rdata_stable", S_AXI_RDATA, e);
            chk("arready_blocked", {31'd0, S_AXI_ARREADY}, 32'd0);
         end
         @(posedge ACLK); #1;
         S_AXI_RREADY = 1'b1;
         @(negedge ACLK);
      end
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int awd, input int wd, input int bd);
      model[a[3:2]] = ref_write(model[a[3:2]], d, s);
      exp_b.push_back(2'b00);
      exp_p.push_back(4'b0001 << a[3:2]);
      fork
         aw_chan(a, awd);
         w_chan(d, s, wd);
         b_chan(bd);
      join
      for (int i = 0; i < 4; i++) chk($sformatf("reg_o[%0d]", i), reg_o[i], model[i]);
   endtask

   task automatic rd_x(input logic [3:0] a, input logic [31:0] e, input int ard, input int rdly);
      exp_r.push_back(e);
      ar_chan(a, ard);
      r_chan(e, rdly);
   endtask

   task automatic rd(input logic [3:0] a, input int ard, input int rdly);
      rd_x(a, model[a[3:2]], ard, rdly);
   endtask

   task automatic chk_reset_state();
      chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      chk("rst_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
      chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
      chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
      chk("rst_pulse", {28'd0, wr_pulse_o}, 32'd0);
      chk("rst_rdata", S_AXI_RDATA, 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_reg_o[%0d]", i), reg_o[i], 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old;
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk_reset_state();
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("ready_after_rst_aw", {31'd0, S_AXI_AWREADY}, 32'd1);
      chk("ready_after_rst_w", {31'd0, S_AXI_WREADY}, 32'd1);
      chk("ready_after_rst_ar", {31'd0, S_AXI_ARREADY}, 32'd1);
      @(posedge ACLK); #1;

      // Reset between AW and W abandons the write
      aw_chan(4'h8, 0);
      ARESET = 1'b1;
      @(negedge ACLK);
      chk_reset_state();
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      w_chan(32'hDEADBEEF, 4'hF, 0);
      repeat (4) begin
         @(negedge ACLK);
         chk("no_b_after_rst", {31'd0, S_AXI_BVALID}, 32'd0);
      end
      @(posedge ACLK); #1;
      rd(4'h8, 0, 0);
      // Held W now pairs with a fresh AW
      model[2] = 32'hDEADBEEF;
      exp_b.push_back(2'b00);
      exp_p.push_back(4'b0100);
      fork
         aw_chan(4'h8, 0);
         b_chan(0);
      join
      rd_x(4'h8, 32'hDEADBEEF, 0, 0);

      // Basic write/read of all four registers
      for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) rd_x(4'(i * 4), 32'(i + 1), 0, 0);

      // W three cycles ahead of AW: B one cycle after AW handshake
      model[2] = 32'hA5A5A5A5;
      exp_b.push_back(2'b00);
      exp_p.push_back(4'b0100);
      fork
         w_chan(32'hA5A5A5A5, 4'hF, 0);
         begin
            aw_chan(4'hA, 3);
            @(negedge ACLK);
            chk("b_early", {31'd0, S_AXI_BVALID}, 32'd0);
            @(negedge ACLK);
            chk("b_latency", {31'd0, S_AXI_BVALID}, 32'd1);
            chk("pulse_0100", {28'd0, wr_pulse_o}, 32'h4);
         end
         b_chan(0);
      join

      // Byte strobes
      wr(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      wr(4'h5, 32'h12345678, 4'b0101, 1, 0, 0);
      rd_x(4'h4, 32'hFF34FF78, 0, 0);
      wr(4'h0, 32'hCAFEF00D, 4'b0000, 0, 2, 0);
      rd_x(4'h0, 32'h1, 0, 0);

      // B back-pressure, then a second write
      wr(4'hC, 32'h55AA55AA, 4'hF, 0, 0, 10);
      wr(4'hC, 32'h00000066, 4'hF, 1, 0, 0);
      rd(4'hC, 0, 0);

      // R back-pressure with ARADDR wandering
      rd_x(4'h8, 32'hA5A5A5A5, 0, 5);

      // Read on the commit edge returns the old value
      old = model[2];
      fork
         wr(4'h8, 32'h0BADF00D, 4'hF, 0, 0, 0);
         rd_x(4'h8, old, 1, 0);
      join
      rd(4'h8, 0, 0);

      // Random mix
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(1, 0) == 1)
            wr(4'($urandom), $urandom, 4'($urandom), $urandom_range(3, 0),
               $urandom_range(3, 0), $urandom_range(3, 0));
         else
            rd(4'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));
      end

      repeat (3) @(negedge ACLK);
      chk("drain_b", 32'(exp_b.size()), 32'd0);
      chk("drain_r", 32'(exp_r.size()), 32'd0);
      chk("drain_pulse", 32'(exp_p.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ro_puf_axil_slave.md
RO_PUF_AXIL_SLAVE -- requirements
Module: ro_puf_axil_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; selects 4 word registers.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 ACLK  in  1  sole clock; all logic updates on its rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 S_AXI_AWADDR in 4, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write-address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write-data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write-response channel.
REQ-009 S_AXI_ARADDR in 4, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read-address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read-data channel.
REQ-011 reg_o  out  4x32  current contents of registers 0..3, toward the PUF core.
REQ-012 wr_pulse_o  out  4  one-cycle strobe per register, high in the cycle after that register is written.

Function
REQ-013 The block SHALL implement four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, decoded from address bits [3:2]; bits [1:0] and all PROT inputs SHALL be ignored.
REQ-014 AW and W SHALL be accepted independently, in either order or in the same cycle, each into its own holding register.
REQ-015 S_AXI_AWREADY SHALL equal (no address held) AND NOT BVALID; S_AXI_WREADY SHALL equal (no data held) AND NOT BVALID.
REQ-016 Commit: on the rising edge that ends the first cycle in which both address and data are held, the selected register SHALL update byte-wise per WSTRB. On that same edge, BVALID SHALL rise, both holding flags SHALL clear, and the matching wr_pulse_o bit SHALL assert for exactly one cycle.
REQ-017 Latency: AW and W handshaken together at edge N produce a register update and BVALID at edge N+1.
REQ-018 BRESP SHALL always be OKAY (2'b00). BVALID SHALL hold until BREADY; no new AW or W is accepted while BVALID is high.
REQ-019 S_AXI_ARREADY SHALL equal NOT RVALID. On an AR handshake, RDATA SHALL register the addressed value and RVALID SHALL rise on that edge; RDATA/RVALID SHALL hold stable until RREADY. RRESP SHALL always be OKAY.
REQ-020 A read handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-021 The read and write paths SHALL operate concurrently and independently.
REQ-022 A WSTRB of 4'b0000 SHALL still complete the transaction (BVALID, pulse) without changing the register.

Reset
REQ-023 While ARESET=1: all registers, RDATA, reg_o = 0; AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse_o = 0; holding flags cleared.
REQ-024 ARESET asserted mid-transaction SHALL abandon the transaction with no register update and no response; ready signals SHALL rise in the first cycle after reset deasserts.

Structure
REQ-025 Package ro_puf_axil_pkg SHALL hold NUM_REGS=4, register offset constants, RESP_OKAY=2'b00 and the register-array typedef.
REQ-026 The design SHALL be a single module with no sub-modules; the byte-strobe merge SHALL be a function in the package.

Verification
REQ-027 Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC; read back -> RDATA 0x1..0x4, all responses OKAY, reg_o matches.
REQ-028 Write data presented 3 cycles before address to 0x8 (data 0xA5A5A5A5) -> BVALID exactly 1 cycle after the AW handshake; wr_pulse_o=4'b0100 for one cycle.
REQ-029 Write 0xFFFFFFFF to 0x4, then 0x12345678 with WSTRB 4'b0101 -> read returns 0xFF34FF78.
REQ-030 Hold BREADY low 10 cycles after a write -> BVALID held; AWREADY and WREADY low throughout; a second write completes after BREADY.
REQ-031 Hold RREADY low 5 cycles with ARADDR changing -> RDATA stable, ARREADY low until RREADY handshake.
REQ-032 Assert ARESET between AW and W handshakes -> no BVALID and register unchanged (0); a subsequent full write succeeds.
